// File: rtl/command_queue_pkg.sv
// Shared constants and types for the command byte queue.
package command_queue_pkg;

    // Default number of stored command bytes
    localparam int CMD_QUEUE_DEPTH = 4;

    // Filler byte from the uart receiver; it carries no command and is never stored
    localparam logic [7:0] IDLE_BYTE = 8'h00;

    typedef logic [7:0] byte_t;

endpackage : command_queue_pkg

// File: rtl/command_queue_if.sv
// Byte handshakes around the command queue:
// rx_* from the uart receiver, cmd_* to the main controller.
interface command_queue_if;
    import command_queue_pkg::*;

    byte_t rx_data;
    logic  rx_valid;
    logic  rx_ready;
    byte_t cmd_data;
    logic  cmd_valid;
    logic  cmd_ready;

    // Environment side: feeds received bytes in and consumes commands
    modport master (
        output rx_data, rx_valid, cmd_ready,
        input  rx_ready, cmd_data, cmd_valid
    );

    // Queue side
    modport slave (
        input  rx_data, rx_valid, cmd_ready,
        output rx_ready, cmd_data, cmd_valid
    );

endinterface : command_queue_if

// File: rtl/command_queue.sv
// Small FIFO of command bytes between the uart receiver and the main controller.
// The uart side is never stalled: bytes arriving while full are dropped and
// flagged in a sticky overflow bit.
module command_queue #(
    parameter int         DEPTH     = command_queue_pkg::CMD_QUEUE_DEPTH,
    parameter logic [7:0] IDLE_BYTE = command_queue_pkg::IDLE_BYTE
) (
    input  logic                     clk,
    input  logic                     reset,
    command_queue_if.slave           bus,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);
    import command_queue_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    byte_t            mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic full;
    logic rx_byte;
    logic pop;
    logic push;
    logic drop;

    // Handshake outputs; head byte comes straight from storage
    assign bus.rx_ready  = ~reset;
    assign bus.cmd_valid = ~reset & (count != '0);
    assign bus.cmd_data  = mem[rd_ptr];

    assign full    = (count == FULL_CNT);
    assign rx_byte = bus.rx_valid & bus.rx_ready & (bus.rx_data != IDLE_BYTE);
    assign pop     = bus.cmd_valid & bus.cmd_ready;
    // A pop in the same cycle frees the slot the new byte needs
    assign push    = rx_byte & (~full | pop);
    assign drop    = rx_byte & full & ~pop;

    // Storage write; contents need no reset since count guards every read
    always_ff @(posedge clk) begin
        if (push && !flush && !reset)
            mem[wr_ptr] <= bus.rx_data;
    end

    // Pointers, occupancy and sticky overflow; reset beats flush beats push/pop
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (drop)
                overflow <= 1'b1;
        end
    end

endmodule : command_queue

// File: tb/tb_command_queue.sv
// Bench for command_queue: directed scenarios then random traffic, all
// compared cycle by cycle against a queue-based reference model.
module tb_command_queue;
    import command_queue_pkg::*;

    localparam int         DEPTH = 4;
    localparam logic [7:0] IDLE  = 8'h00;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    flush;
    logic [$clog2(DEPTH):0]  count;
    logic                    overflow;

    command_queue_if bus ();

    command_queue #(.DEPTH(DEPTH), .IDLE_BYTE(IDLE)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .flush    (flush),
        .count    (count),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    byte_t q[$];
    bit    m_ovf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs, check outputs against the model before
    // the edge, advance the model by the queue rules, then cross the edge.
    task automatic step(input logic rv, input byte_t rd, input logic cr,
                        input logic fl, input logic rs, input string tag);
        bus.rx_valid  = rv;
        bus.rx_data   = rd;
        bus.cmd_ready = cr;
        flush         = fl;
        reset         = rs;
        #1;
        if (rs) begin
            chk({tag, ".rx_ready_rst"}, bus.rx_ready, 0);
            chk({tag, ".cmd_valid_rst"}, bus.cmd_valid, 0);
        end else begin
            chk({tag, ".rx_ready"}, bus.rx_ready, 1);
            chk({tag, ".cmd_valid"}, bus.cmd_valid, q.size() != 0);
            chk({tag, ".count"}, count, q.size());
            chk({tag, ".overflow"}, overflow, m_ovf);
            if (q.size() != 0)
                chk({tag, ".cmd_data"}, bus.cmd_data, q[0]);
        end
        if (rs || fl) begin
            q.delete();
            m_ovf = 1'b0;
        end else begin
            if (cr && q.size() != 0)
                void'(q.pop_front());
            if (rv && rd != IDLE) begin
                if (q.size() < DEPTH) q.push_back(rd);
                else                  m_ovf = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input string tag);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, tag);
    endtask

    task automatic drain(input int n, input string tag);
        for (int i = 0; i < n; i++)
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, tag);
    endtask

    initial begin
        bus.rx_valid  = 1'b0;
        bus.rx_data   = 8'h00;
        bus.cmd_ready = 1'b0;
        flush         = 1'b0;
        reset         = 1'b1;
        @(negedge clk);

        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "rst");
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "rst");
        idle("after_rst");
        chk("rst_count", count, 0);
        chk("rst_overflow", overflow, 0);

        // Three bytes in, then drained in order
        step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, "r31");
        chk("r31_latency_valid", bus.cmd_valid, 1);
        chk("r31_latency_data", bus.cmd_data, 8'h11);
        step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, "r31");
        step(1'b1, 8'h33, 1'b0, 1'b0, 1'b0, "r31");
        chk("r31_count3", count, 3);
        chk("r31_head", bus.cmd_data, 8'h11);
        drain(3, "r31_drain");
        chk("r31_empty_count", count, 0);
        chk("r31_empty_valid", bus.cmd_valid, 0);

        // Overflow on the fifth byte
        for (int i = 1; i <= 5; i++)
            step(1'b1, byte_t'(8'hA0 + i), 1'b0, 1'b0, 1'b0, "r32");
        chk("r32_count", count, 4);
        chk("r32_overflow", overflow, 1);
        drain(5, "r32_drain");
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "r32_flush");
        chk("r32_flush_ovf", overflow, 0);

        // Full queue, simultaneous push and pop
        for (int i = 0; i < 4; i++)
            step(1'b1, byte_t'(8'hC0 + i), 1'b0, 1'b0, 1'b0, "r33_fill");
        step(1'b1, 8'hB5, 1'b1, 1'b0, 1'b0, "r33");
        chk("r33_count", count, 4);
        chk("r33_overflow", overflow, 0);
        drain(4, "r33_drain");

        // Idle byte on empty queue
        step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, "r34");
        chk("r34_count", count, 0);
        chk("r34_valid", bus.cmd_valid, 0);
        chk("r34_overflow", overflow, 0);

        // Flush overriding push and pop
        step(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, "r35_fill");
        step(1'b1, 8'h02, 1'b0, 1'b0, 1'b0, "r35_fill");
        step(1'b1, 8'h44, 1'b1, 1'b1, 1'b0, "r35");
        chk("r35_count", count, 0);
        chk("r35_overflow", overflow, 0);
        chk("r35_valid", bus.cmd_valid, 0);

        // Reset mid-operation, then pointer wrap
        for (int i = 0; i < 5; i++)
            step(1'b1, byte_t'(8'h60 + i), 1'b0, 1'b0, 1'b0, "r36_fill");
        chk("r36_pre_ovf", overflow, 1);
        step(1'b1, 8'h77, 1'b1, 1'b0, 1'b1, "r36_rst");
        chk("r36_count", count, 0);
        chk("r36_overflow", overflow, 0);
        step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, "r36");
        chk("r36_head", bus.cmd_data, 8'h55);
        for (int i = 0; i < 10; i++)
            step(1'b1, byte_t'(8'h80 + i), 1'b1, 1'b0, 1'b0, "r36_wrap");
        drain(2, "r36_drain");

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            logic  rv, cr, fl, rs;
            byte_t rd;
            rv = ($urandom_range(0, 3) != 0);
            rd = ($urandom_range(0, 5) == 0) ? IDLE : byte_t'($urandom);
            cr = ($urandom_range(0, 2) == 0);
            fl = ($urandom_range(0, 60) == 0);
            rs = ($urandom_range(0, 100) == 0);
            step(rv, rd, cr, fl, rs, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_command_queue
